// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush-to-bubble,
// and saturating stall/flush statistics. in_ready is registered, so backpressure never crosses the stage combinationally.
module pipe_stage_skid #(
    parameter int unsigned              DATA_W     = 160,
    parameter logic [DATA_W-1:0]        BUBBLE_VAL = '0,
    parameter int unsigned              CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        occupancy
);

    // The state is simply {main_v, skid_v}.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        ILLEGAL = 2'b01,
        ONE     = 2'b10,
        TWO     = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;
    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    state_t            state;
    logic              in_xfer;
    logic              out_xfer;
    logic [1:0]        drop_n;
    logic [CNT_W:0]    flush_sum;

    assign state    = state_t'({main_v_q, skid_v_q});
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = main_v_q & out_ready;

    // Entries lost to a flush: the main entry only if it did not leave this cycle.
    assign drop_n    = {1'b0, main_v_q & ~out_xfer} + {1'b0, skid_v_q};
    assign flush_sum = {1'b0, flush_cnt_q} + {{(CNT_W-1){1'b0}}, drop_n};

    always_comb begin
        main_d_d    = main_d_q;
        skid_d_d    = skid_d_q;
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (rst) begin
            main_d_d    = BUBBLE_VAL;
            skid_d_d    = BUBBLE_VAL;
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (main_v_q && !out_ready && stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + 1'b1;

            if (flush) begin
                main_d_d    = BUBBLE_VAL;
                skid_d_d    = BUBBLE_VAL;
                main_v_d    = 1'b0;
                skid_v_d    = 1'b0;
                flush_cnt_d = flush_sum[CNT_W] ? CNT_MAX : flush_sum[CNT_W-1:0];
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_d_d = in_data;
                            main_v_d = 1'b1;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_d_d = in_data;
                        end else if (in_xfer) begin
                            skid_d_d = in_data;
                            skid_v_d = 1'b1;
                        end else if (out_xfer) begin
                            main_v_d = 1'b0;
                        end
                    end
                    TWO: begin
                        if (out_xfer) begin
                            main_d_d = skid_d_q;
                            skid_v_d = 1'b0;
                        end
                    end
                    default: begin
                        main_v_d = 1'b0;
                        skid_v_d = 1'b0;
                    end
                endcase
            end
        end

        in_ready_d = ~skid_v_d;
    end

    always_ff @(posedge clk) begin
        main_d_q    <= main_d_d;
        skid_d_q    <= skid_d_d;
        main_v_q    <= main_v_d;
        skid_v_q    <= skid_v_d;
        in_ready_q  <= in_ready_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_d_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, skid backpressure, flush, counter saturation, mid-run reset.
module tb_pipe_stage_skid;

    localparam int unsigned       DW  = 32;
    localparam int unsigned       CW  = 4;
    localparam logic [DW-1:0]     BUB = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]    occupancy;

    int n_chk = 0;
    int n_fail = 0;

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (out_data !== BUB) begin n_fail++; $display("FAIL reset_out_data got %h want %h", out_data, BUB); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_chk++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        n_chk++; if (flush_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_flush got %0d want 0", flush_cnt); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = DW'(i);
            tick();
            n_chk++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, DW'(i)); end
            n_chk++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_ready_occ[%0d] got rdy=%b occ=%0d want rdy=1 occ=1", i, in_ready, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        n_chk++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
        n_chk++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL stream_stall got %0d want 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 32'hA;
        tick();
        n_chk++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || stall_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_first got occ=%0d rdy=%b stall=%0d want 1 1 0", occupancy, in_ready, stall_cnt); end
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        n_chk++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready); end
        n_chk++; if (out_data !== 32'hA || stall_cnt !== 4'd1) begin n_fail++; $display("FAIL bp_hold1 got d=%h stall=%0d want d=a stall=1", out_data, stall_cnt); end
        tick();
        tick();
        n_chk++; if (out_data !== 32'hA || out_valid !== 1'b1 || stall_cnt !== 4'd3) begin n_fail++; $display("FAIL bp_hold3 got v=%b d=%h stall=%0d want v=1 d=a stall=3", out_valid, out_data, stall_cnt); end
        out_ready = 1'b1;
        tick();
        n_chk++; if (out_data !== 32'hB || out_valid !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain1 got v=%b d=%h occ=%0d rdy=%b want 1 b 1 1", out_valid, out_data, occupancy, in_ready); end
        tick();
        n_chk++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 4'd3) begin n_fail++; $display("FAIL bp_drain2 got v=%b occ=%0d stall=%0d want 0 0 3", out_valid, occupancy, stall_cnt); end
    endtask

    task automatic test_flush_two();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 32'h1A;
        tick();
        in_data = 32'h1B;
        tick();
        n_chk++; if (occupancy !== 2'd2 || stall_cnt !== 4'd4) begin n_fail++; $display("FAIL ft_setup got occ=%0d stall=%0d want 2 4", occupancy, stall_cnt); end
        flush = 1'b1; in_data = 32'hC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0) begin n_fail++; $display("FAIL ft_state got v=%b d=%h occ=%0d want v=0 d=%h occ=0", out_valid, out_data, occupancy, BUB); end
        n_chk++; if (flush_cnt !== 4'd2 || stall_cnt !== 4'd5 || in_ready !== 1'b1) begin n_fail++; $display("FAIL ft_cnt got fl=%0d st=%0d rdy=%b want 2 5 1", flush_cnt, stall_cnt, in_ready); end
        out_ready = 1'b1;
        tick();
        n_chk++; if (out_valid !== 1'b0 || out_data === 32'hC) begin n_fail++; $display("FAIL ft_dropped got v=%b d=%h want v=0 and not c", out_valid, out_data); end
    endtask

    task automatic test_flush_one();
        out_ready = 1'b1;
        in_valid  = 1'b1; in_data = 32'h21;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        n_chk++; if (out_valid !== 1'b1 || out_data !== 32'h21) begin n_fail++; $display("FAIL fo_present got v=%b d=%h want 1 21", out_valid, out_data); end
        tick();
        flush = 1'b0;
        n_chk++; if (flush_cnt !== 4'd2 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fo_taken got fl=%0d v=%b want 2 0", flush_cnt, out_valid); end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h22;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_chk++; if (flush_cnt !== 4'd3 || stall_cnt !== 4'd6 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fo_drop got fl=%0d st=%0d v=%b want 3 6 0", flush_cnt, stall_cnt, out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 32'h33;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_chk++; if (stall_cnt !== 4'd11) begin n_fail++; $display("FAIL sat_mid got %0d want 11", stall_cnt); end
        for (int i = 0; i < 15; i++) tick();
        n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stick got %0d want 15", stall_cnt); end
        n_chk++; if (out_data !== 32'h33 || out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_hold got v=%b d=%h want 1 33", out_valid, out_data); end
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1; in_data = 32'h44;
        tick();
        n_chk++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL mr_setup got occ=%0d want 2", occupancy); end
        rst = 1'b1; in_data = 32'h55;
        tick();
        rst = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_state got v=%b d=%h occ=%0d rdy=%b want 0 %h 0 1", out_valid, out_data, occupancy, in_ready, BUB); end
        n_chk++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_fail++; $display("FAIL mr_cnt got st=%0d fl=%0d want 0 0", stall_cnt, flush_cnt); end
        out_ready = 1'b1; in_data = 32'h66;
        tick();
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_data !== 32'h66 || occupancy !== 2'd1) begin n_fail++; $display("FAIL mr_after got v=%b d=%h occ=%0d want 1 66 1", out_valid, out_data, occupancy); end
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_drain got v=%b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_two();
        test_flush_one();
        test_saturation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline-stage register; successor to the fixed-width IF/ID style latch.
- Replaces the stall/flush register pair with a valid/ready handshake and a 2-entry skid buffer. in_ready is fully registered, so backpressure never forms a combinational path across the stage.
- Adds flush with a programmable bubble value and saturating stall/flush statistics counters.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...); the hazard unit drives out_ready low to stall and pulses flush on branch mispredict.

Parameters:
- DATA_W, 160, payload width (e.g. pc 64 + pc+4 64 + inst 32).
- BUBBLE_VAL, 0, value loaded into both data registers on flush and reset ({DATA_W} bits).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset: synchronous, active-high.
- flush, input, 1, discard all held entries this cycle.
- in_valid, input, 1, upstream has data.
- in_data, input, DATA_W, upstream payload.
- in_ready, output, 1, stage can accept; registered.
- out_valid, output, 1, out_data is valid.
- out_data, output, DATA_W, payload; driven from the main register only.
- out_ready, input, 1, downstream accepts.
- stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0; saturating.
- flush_cnt, output, CNT_W, number of valid entries discarded by flush; saturating.
- occupancy, output, 2, entries held (0..2).

Behaviour:

Storage:
- Main register (main_d, main_v) and skid register (skid_d, skid_v).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.

State machine (encoded by main_v/skid_v):
- EMPTY (0,0): no transfer out possible. Transfer in -> main=in_data, go to ONE.
- ONE (1,0):
  - in & out -> main=in_data, stay ONE (full throughput, 1 item/cycle).
  - in only -> skid=in_data, go to TWO.
  - out only -> go to EMPTY.
  - neither -> hold.
- TWO (1,1): in_ready=0, so no transfer in.
  - out -> main=skid_d, skid_v=0, go to ONE.
  - else -> hold.
- Illegal (0,1): must be unreachable; if reached, go to EMPTY on the next edge.

Registered outputs and derived signals:
- in_ready register is loaded with !(next skid_v); it equals 1 in EMPTY and ONE, 0 in TWO.
- out_valid = main_v.
- occupancy = main_v + skid_v.
- Latency: in_data appears on out_data exactly 1 cycle after its transfer in when the stage was EMPTY or draining.

Flush:
- Priority: rst > flush > handshake.
- On flush: main_v=0, skid_v=0, main_d=skid_d=BUBBLE_VAL, in_ready<=1.
- A simultaneous in_valid in the flush cycle is dropped and not counted as accepted.
- A simultaneous out transfer in the flush cycle still completes downstream; that entry is not counted in flush_cnt.
- flush_cnt increments by the number of entries discarded: (main_v & !(out_valid&out_ready)) + skid_v, saturating at 2^CNT_W-1.

stall_cnt:
- +1 per cycle with out_valid & !out_ready, saturating at 2^CNT_W-1.
- Counts during the flush cycle if that condition holds.

Reset:
- All outputs reach their reset values on the first clk edge with rst=1; this is also true mid-transfer.
- Reset values: out_valid=0, out_data=BUBBLE_VAL, in_ready=1, occupancy=0, stall_cnt=0, flush_cnt=0. skid_d=BUBBLE_VAL.
- in_ready=1 from the reset cycle onward.

Data hold rules:
- out_data must hold stable while out_valid=1 and out_ready=0.
- Data registers are not updated when no transfer occurs.
- Widths: counters are unsigned; no truncation warnings; occupancy is zero-extended.

Test Plan:
1. Streaming: rst, then in_valid=1 every cycle with data 1,2,3,...; out_ready=1 -> out_data 1,2,3 one cycle behind; in_ready stays 1; occupancy=1 steady; stall_cnt=0.
2. Backpressure/skid: send A=0xA, B=0xB with out_ready=0 -> occupancy=2, in_ready=0 in the cycle after B; out_data holds 0xA; stall_cnt increments each stalled cycle. Raise out_ready -> out_data 0xA then 0xB, in_ready returns to 1; no loss or duplication.
3. Flush in TWO with out_ready=0 and in_valid=1 (data 0xC) -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0, flush_cnt=2; 0xC never appears on the output.
4. Flush in ONE with out_ready=1 -> the held entry transfers downstream and flush_cnt is unchanged. Then flush with out_ready=0 -> flush_cnt increments by 1.
5. Saturation with CNT_W=4: hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt sticks at 15.
6. Mid-operation reset in TWO with counters nonzero -> next edge: all outputs at reset values, in_ready=1. A new item sent afterwards emerges 1 cycle later.
